systolic_seq: RTL and testbench

Sequencer for one DIM×DIM systolic matrix-multiply pass. It drives row reads from the A/B operand stores and steps the skew buffers and the MAC array. It then hands result rows out over a valid/ready port and pulses `done`. It sits between the host command path and the A/B skew buffers plus MAC array, and it keeps each skew buffer's internal row pointer aligned across runs and aborts.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_seq.sv | 89 ++++++++
 tb/tb_systolic_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and sizing helpers for the systolic sequencer.
package systolic_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COMPUTE, S_RESULT, S_DONE, S_FLUSH} seq_state_t;
  localparam int DEF_DIM = 8;
  function automatic int run_len(input int d);
    return 3 * d;
  endfunction
  function automatic int flush_len(input int d);
    return 2 * d - 1;
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(3 * d + 1);
  endfunction
  localparam int RUN_LEN   = run_len(DEF_DIM);
  localparam int FLUSH_LEN = flush_len(DEF_DIM);
  localparam int CNT_W     = cnt_w(DEF_DIM);
endpackage

// File: rtl/systolic_seq.sv
// systolic_seq: sequences one DIMxDIM systolic pass and keeps skew-buffer row pointers aligned.
module systolic_seq
  import systolic_pkg::*;
#(
  parameter int DIM = DEF_DIM,
  parameter int AW  = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          buf_en,
  output logic          zero_fill,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_row
);
  localparam int RUN = run_len(DIM);
  localparam int FL  = flush_len(DIM);
  localparam int CW  = cnt_w(DIM);
  seq_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_zc;
  logic [AW-1:0] r_ph;
  logic [AW-1:0] r_res_row;
  logic          w_comp;
  logic          w_flush;
  logic [AW-1:0] w_ph_nxt;
  assign w_comp    = r_state == S_COMPUTE;
  assign w_flush   = r_state == S_FLUSH;
  assign w_ph_nxt  = (r_ph == AW'(DIM - 1)) ? '0 : r_ph + 1'b1;
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_DONE;
  assign mac_clr   = r_state == S_CLEAR;
  assign res_valid = r_state == S_RESULT;
  assign rd_en     = w_comp && r_cnt < CW'(DIM);
  assign rd_addr   = rd_en ? r_cnt[AW-1:0] : '0;
  assign buf_en    = (w_comp && r_cnt != '0) || w_flush;
  assign zero_fill = (w_comp && r_cnt > CW'(DIM)) || w_flush;
  assign mac_en    = w_comp && r_cnt != '0 && r_cnt <= CW'(RUN - 2);
  assign res_row   = res_valid ? r_res_row : '0;
  // r_ph tracks every buffer pulse so FLUSH can stop exactly when the buffers' pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_zc      <= '0;
      r_ph      <= '0;
      r_res_row <= '0;
    end else begin
      if (buf_en) r_ph <= w_ph_nxt;
      case (r_state)
        S_IDLE:    if (start && !abort) r_state <= S_CLEAR;
        S_CLEAR: begin
          r_cnt   <= '0;
          r_state <= abort ? S_IDLE : S_COMPUTE;
        end
        S_COMPUTE: begin
          if (abort) begin
            r_state <= S_FLUSH;
            r_zc    <= '0;
          end else if (r_cnt == CW'(RUN)) begin
            r_state   <= S_RESULT;
            r_res_row <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end
        S_RESULT: begin
          if (abort) r_state <= S_IDLE;
          else if (res_ready) begin
            r_res_row <= (r_res_row == AW'(DIM - 1)) ? '0 : r_res_row + 1'b1;
            if (r_res_row == AW'(DIM - 1)) r_state <= S_DONE;
          end
        end
        S_DONE:    r_state <= S_IDLE;
        S_FLUSH: begin
          r_zc <= r_zc + 1'b1;
          if (r_zc >= CW'(FL - 1) && w_ph_nxt == '0) r_state <= S_IDLE;
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: directed cycle-by-cycle checks of systolic_seq with DIM=8.
module tb_systolic_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       res_ready = 1'b1;
  logic       busy, done, rd_en, buf_en, zero_fill, mac_en, mac_clr, res_valid;
  logic [2:0] rd_addr, res_row;
  logic [13:0] obs;
  int checks = 0;
  int errors = 0;
  systolic_seq #(.DIM(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .buf_en(buf_en), .zero_fill(zero_fill),
    .mac_en(mac_en), .mac_clr(mac_clr), .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row)
  );
  always #5 clk = ~clk;
  assign obs = {busy, done, rd_en, rd_addr, buf_en, zero_fill, mac_en, mac_clr, res_valid, res_row};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Cycle c is the cycle in which start is high; s stalls res_ready for s cycles at row 4.
  task automatic run(input string name, input int s, input bit noise, input int abort_c, input int rst_c);
    int dones = 0;
    int fl = 0;
    int k, row;
    logic [13:0] e;
    for (int c = 0; c <= 40 + s; c++) begin
      @(negedge clk);
      if ((rst_c >= 0 && c > rst_c) || (abort_c >= 0 && c > abort_c + 19)) e = '0;
      else if (abort_c >= 0 && c > abort_c) e = {1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      else begin
        k = c - 27;
        row = k < 4 ? k : (k <= 4 + s ? 4 : k - s);
        e = {c >= 1 && c <= 35 + s, c == 35 + s, c >= 2 && c <= 9,
             (c >= 2 && c <= 9) ? 3'(c - 2) : 3'd0,
             c >= 3 && c <= 26, c >= 11 && c <= 26, c >= 3 && c <= 24, c == 1,
             c >= 27 && c <= 34 + s, (c >= 27 && c <= 34 + s) ? 3'(row) : 3'd0};
      end
      check($sformatf("%s c%0d", name, c), 32'(obs), 32'(e));
      dones += int'(done);
      if (abort_c >= 0 && c > abort_c && buf_en) fl++;
      start = c == 0 || (noise && (c == 10 || c == 29));
      abort = c == abort_c;
      rst = c == rst_c;
      res_ready = !(c >= 31 && c < 31 + s);
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
    res_ready = 1'b1;
    check({name, " dones"}, dones, (abort_c < 0 && rst_c < 0) ? 1 : 0);
    if (abort_c >= 0) check({name, " flush_pulses"}, fl, 19);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset", 32'(obs), 0);
    rst = 1'b0;
    run("nominal", 0, 1'b0, -1, -1);
    run("stall", 3, 1'b0, -1, -1);
    run("abort", 0, 1'b0, 7, -1);
    run("post_abort", 0, 1'b0, -1, -1);
    run("start_noise", 0, 1'b1, -1, -1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("start_abort c%0d", i), 32'(obs), 0);
    end
    run("rst_result", 0, 1'b0, -1, 29);
    run("post_rst", 0, 1'b0, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
